// File: rtl/mc_pkg.sv
// mc_pkg: shared constants and types for the multi-cycle control unit.
// States, opcodes, funct codes, ALU codes and PC sources.
package mc_pkg;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  typedef enum logic [2:0] {
    C_RTYPE,
    C_ALUI,
    C_LW,
    C_SW,
    C_BEQ,
    C_BNE,
    C_J
  } icls_t;

endpackage

// File: rtl/mc_if.sv
// mc_if: control-unit to datapath bundle.
// master = controller side, slave = datapath/memory side.
interface mc_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       ir_we;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       rf_we;
  logic       wsel_rt;
  logic       wb_mem;
  logic       srca_shamt;
  logic       srcb_imm;
  logic       sign_ext;
  logic [2:0] alu_op;
  logic       trap;
  logic [2:0] state_o;

  modport master (
    input  op, funct, zero, mem_ready,
    output pc_we, pc_src, ir_we, mem_req, mem_we, iord,
    output rf_we, wsel_rt, wb_mem, srca_shamt, srcb_imm,
    output sign_ext, alu_op, trap, state_o
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pc_we, pc_src, ir_we, mem_req, mem_we, iord,
    input  rf_we, wsel_rt, wb_mem, srca_shamt, srcb_imm,
    input  sign_ext, alu_op, trap, state_o
  );
endinterface

// File: rtl/mc_decode.sv
// mc_decode: combinational op/funct classifier.
// Produces instruction class, ALU op, extension mode and illegal flag.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output icls_t      cls,
  output logic [2:0] alu_op,
  output logic       sign_ext,
  output logic       shamt,
  output logic       illegal
);

  always_comb begin
    cls      = C_RTYPE;
    alu_op   = ALU_ADD;
    sign_ext = 1'b0;
    shamt    = 1'b0;
    illegal  = 1'b0;
    unique case (1'b1)
      op == OP_RTYPE: begin
        cls = C_RTYPE;
        case (funct)
          F_SLL: begin
            alu_op = ALU_SLL;
            shamt  = 1'b1;
          end
          F_ADDU:  alu_op = ALU_ADD;
          F_SUBU:  alu_op = ALU_SUB;
          F_AND:   alu_op = ALU_AND;
          F_OR:    alu_op = ALU_OR;
          F_XOR:   alu_op = ALU_XOR;
          F_NOR:   alu_op = ALU_NOR;
          F_SLT:   alu_op = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      op == OP_J:   cls = C_J;
      op == OP_BEQ: begin
        cls    = C_BEQ;
        alu_op = ALU_SUB;
      end
      op == OP_BNE: begin
        cls    = C_BNE;
        alu_op = ALU_SUB;
      end
      op == OP_ADDIU: begin
        cls      = C_ALUI;
        sign_ext = 1'b1;
      end
      op == OP_SLTI: begin
        cls      = C_ALUI;
        alu_op   = ALU_SLT;
        sign_ext = 1'b1;
      end
      op == OP_ANDI: begin
        cls    = C_ALUI;
        alu_op = ALU_AND;
      end
      op == OP_ORI: begin
        cls    = C_ALUI;
        alu_op = ALU_OR;
      end
      op == OP_XORI: begin
        cls    = C_ALUI;
        alu_op = ALU_XOR;
      end
      op == OP_LW: begin
        cls      = C_LW;
        sign_ext = 1'b1;
      end
      op == OP_SW: begin
        cls      = C_SW;
        sign_ext = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle FSM sequencing fetch/decode/exec/mem/wb.
// Strobes are decoded from the state and gated off while reset is low.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mc_if.master bus
);

  logic [2:0] state_q;
  logic [2:0] state_d;
  icls_t      cls;
  logic [2:0] dec_alu;
  logic       dec_sext;
  logic       dec_shamt;
  logic       illegal;

  mc_decode u_dec (
    .op       (bus.op),
    .funct    (bus.funct),
    .cls      (cls),
    .alu_op   (dec_alu),
    .sign_ext (dec_sext),
    .shamt    (dec_shamt),
    .illegal  (illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:
        if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (illegal)        state_d = S_TRAP;
        else if (cls == C_J) state_d = S_FETCH;
        else                state_d = S_EXEC;
      end
      S_EXEC: begin
        case (cls)
          C_LW, C_SW:   state_d = S_MEM;
          C_BEQ, C_BNE: state_d = S_FETCH;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM:
        if (bus.mem_ready)
          state_d = (cls == C_LW) ? S_WB : S_FETCH;
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    bus.pc_we      = 1'b0;
    bus.pc_src     = PC_SEQ;
    bus.ir_we      = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.iord       = 1'b0;
    bus.rf_we      = 1'b0;
    bus.wsel_rt    = 1'b0;
    bus.wb_mem     = 1'b0;
    bus.srca_shamt = 1'b0;
    bus.srcb_imm   = 1'b0;
    bus.sign_ext   = 1'b0;
    bus.alu_op     = ALU_ADD;
    // Nothing may strobe while reset is held, even though state reads FETCH.
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          bus.ir_we   = bus.mem_ready;
          bus.pc_we   = bus.mem_ready;
        end
        S_DECODE:
          if (!illegal && cls == C_J) begin
            bus.pc_we  = 1'b1;
            bus.pc_src = PC_JMP;
          end
        S_EXEC: begin
          bus.alu_op     = dec_alu;
          bus.srca_shamt = dec_shamt;
          bus.sign_ext   = dec_sext;
          bus.srcb_imm   = (cls == C_ALUI) || (cls == C_LW) ||
                           (cls == C_SW);
          if (cls == C_BEQ || cls == C_BNE) begin
            bus.pc_src = PC_BR;
            bus.pc_we  = (cls == C_BEQ) ? bus.zero : !bus.zero;
          end
        end
        S_MEM: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
          bus.mem_we  = (cls == C_SW);
        end
        S_WB: begin
          bus.rf_we   = 1'b1;
          bus.wsel_rt = (cls != C_RTYPE);
          bus.wb_mem  = (cls == C_LW);
        end
        default: ;
      endcase
    end
  end

  assign bus.trap    = (state_q == S_TRAP);
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed per-cycle vectors with a scoreboard queue.
// Driver pushes expected outputs; a negedge monitor pops and compares.
module tb_mc_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       rf_we;
    logic       wsel_rt;
    logic       wb_mem;
    logic       srca_shamt;
    logic       srcb_imm;
    logic       sign_ext;
    logic [2:0] alu_op;
    logic       trap;
  } exp_t;

  typedef struct {
    string name;
    exp_t  e;
  } item_t;

  logic  clk = 1'b0;
  logic  reset = 1'b0;
  item_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  mc_if bus ();

  mc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t x(input logic [2:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  task automatic cyc(input string nm, input logic rst,
                     input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rdy, input exp_t e);
    item_t it;
    @(posedge clk);
    #1;
    reset         = rst;
    bus.op        = op;
    bus.funct     = fn;
    bus.zero      = z;
    bus.mem_ready = rdy;
    it.name = nm;
    it.e    = e;
    sb_q.push_back(it);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      item_t it;
      exp_t  g;
      it = sb_q.pop_front();
      g.st         = bus.state_o;
      g.pc_we      = bus.pc_we;
      g.pc_src     = bus.pc_src;
      g.ir_we      = bus.ir_we;
      g.mem_req    = bus.mem_req;
      g.mem_we     = bus.mem_we;
      g.iord       = bus.iord;
      g.rf_we      = bus.rf_we;
      g.wsel_rt    = bus.wsel_rt;
      g.wb_mem     = bus.wb_mem;
      g.srca_shamt = bus.srca_shamt;
      g.srcb_imm   = bus.srcb_imm;
      g.sign_ext   = bus.sign_ext;
      g.alu_op     = bus.alu_op;
      g.trap       = bus.trap;
      checks++;
      if (g !== it.e) begin
        errors++;
        $display("FAIL %s t=%0t got=%h expected=%h",
                 it.name, $time, g, it.e);
      end
    end
  end

  // Expected vectors: state-only baseline plus explicit strobes.
  function automatic exp_t fdone();
    exp_t e;
    e = x(3'd0);
    e.mem_req = 1'b1;
    e.ir_we   = 1'b1;
    e.pc_we   = 1'b1;
    return e;
  endfunction

  function automatic exp_t fwait();
    exp_t e;
    e = x(3'd0);
    e.mem_req = 1'b1;
    return e;
  endfunction

  initial begin
    exp_t e;
    bus.op = '0;
    bus.funct = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;

    cyc("rst0", 0, 6'h00, 6'h21, 0, 1, x(3'd0));
    cyc("rst1", 0, 6'h00, 6'h21, 0, 0, x(3'd0));

    // addu, zero wait states
    cyc("addu_f", 1, 6'h00, 6'b100001, 0, 1, fdone());
    cyc("addu_d", 1, 6'h00, 6'b100001, 0, 1, x(3'd1));
    cyc("addu_e", 1, 6'h00, 6'b100001, 0, 1, x(3'd2));
    e = x(3'd4); e.rf_we = 1'b1;
    cyc("addu_wb", 1, 6'h00, 6'b100001, 0, 1, e);

    // lw with 2 wait states in FETCH and MEM
    cyc("lw_fw0", 1, 6'b100011, 6'h00, 0, 0, fwait());
    cyc("lw_fw1", 1, 6'b100011, 6'h00, 0, 0, fwait());
    cyc("lw_f", 1, 6'b100011, 6'h00, 0, 1, fdone());
    cyc("lw_d", 1, 6'b100011, 6'h00, 0, 0, x(3'd1));
    e = x(3'd2); e.srcb_imm = 1'b1; e.sign_ext = 1'b1;
    cyc("lw_e", 1, 6'b100011, 6'h00, 0, 0, e);
    e = x(3'd3); e.mem_req = 1'b1; e.iord = 1'b1;
    cyc("lw_mw0", 1, 6'b100011, 6'h00, 0, 0, e);
    cyc("lw_mw1", 1, 6'b100011, 6'h00, 0, 0, e);
    cyc("lw_m", 1, 6'b100011, 6'h00, 0, 1, e);
    e = x(3'd4); e.rf_we = 1'b1; e.wsel_rt = 1'b1; e.wb_mem = 1'b1;
    cyc("lw_wb", 1, 6'b100011, 6'h00, 0, 0, e);

    // beq taken, bne not taken, bne taken
    cyc("beq_f", 1, 6'b000100, 6'h00, 1, 1, fdone());
    cyc("beq_d", 1, 6'b000100, 6'h00, 1, 1, x(3'd1));
    e = x(3'd2); e.alu_op = 3'b001; e.pc_src = 2'b01; e.pc_we = 1'b1;
    cyc("beq_e", 1, 6'b000100, 6'h00, 1, 1, e);
    cyc("bne_f", 1, 6'b000101, 6'h00, 1, 1, fdone());
    cyc("bne_d", 1, 6'b000101, 6'h00, 1, 1, x(3'd1));
    e = x(3'd2); e.alu_op = 3'b001; e.pc_src = 2'b01;
    cyc("bne_e_z1", 1, 6'b000101, 6'h00, 1, 1, e);
    cyc("bne2_f", 1, 6'b000101, 6'h00, 0, 1, fdone());
    cyc("bne2_d", 1, 6'b000101, 6'h00, 0, 1, x(3'd1));
    e = x(3'd2); e.alu_op = 3'b001; e.pc_src = 2'b01; e.pc_we = 1'b1;
    cyc("bne_e_z0", 1, 6'b000101, 6'h00, 0, 1, e);

    // j
    cyc("j_f", 1, 6'b000010, 6'h00, 0, 1, fdone());
    e = x(3'd1); e.pc_we = 1'b1; e.pc_src = 2'b10;
    cyc("j_d", 1, 6'b000010, 6'h00, 0, 1, e);

    // sll
    cyc("sll_f", 1, 6'h00, 6'b000000, 0, 1, fdone());
    cyc("sll_d", 1, 6'h00, 6'b000000, 0, 1, x(3'd1));
    e = x(3'd2); e.alu_op = 3'b111; e.srca_shamt = 1'b1;
    cyc("sll_e", 1, 6'h00, 6'b000000, 0, 1, e);
    e = x(3'd4); e.rf_we = 1'b1;
    cyc("sll_wb", 1, 6'h00, 6'b000000, 0, 1, e);

    // ori (zero-extended) and slti (sign-extended)
    cyc("ori_f", 1, 6'b001101, 6'h3f, 0, 1, fdone());
    cyc("ori_d", 1, 6'b001101, 6'h3f, 0, 1, x(3'd1));
    e = x(3'd2); e.alu_op = 3'b011; e.srcb_imm = 1'b1;
    cyc("ori_e", 1, 6'b001101, 6'h3f, 0, 1, e);
    e = x(3'd4); e.rf_we = 1'b1; e.wsel_rt = 1'b1;
    cyc("ori_wb", 1, 6'b001101, 6'h3f, 0, 1, e);
    cyc("slti_f", 1, 6'b001010, 6'h00, 0, 1, fdone());
    cyc("slti_d", 1, 6'b001010, 6'h00, 0, 1, x(3'd1));
    e = x(3'd2); e.alu_op = 3'b110; e.srcb_imm = 1'b1; e.sign_ext = 1'b1;
    cyc("slti_e", 1, 6'b001010, 6'h00, 0, 1, e);
    e = x(3'd4); e.rf_we = 1'b1; e.wsel_rt = 1'b1;
    cyc("slti_wb", 1, 6'b001010, 6'h00, 0, 1, e);

    // sw with reset during MEM wait
    cyc("sw_f", 1, 6'b101011, 6'h00, 0, 1, fdone());
    cyc("sw_d", 1, 6'b101011, 6'h00, 0, 0, x(3'd1));
    e = x(3'd2); e.srcb_imm = 1'b1; e.sign_ext = 1'b1;
    cyc("sw_e", 1, 6'b101011, 6'h00, 0, 0, e);
    e = x(3'd3); e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = 1'b1;
    cyc("sw_mw0", 1, 6'b101011, 6'h00, 0, 0, e);
    cyc("sw_mw1", 1, 6'b101011, 6'h00, 0, 0, e);
    cyc("sw_rst0", 0, 6'b101011, 6'h00, 0, 0, x(3'd0));
    cyc("sw_rst1", 0, 6'b101011, 6'h00, 0, 1, x(3'd0));
    cyc("sw_rel", 1, 6'b101011, 6'h00, 0, 0, fwait());

    // illegal opcode traps and holds
    cyc("ill_f", 1, 6'b111111, 6'h00, 0, 1, fdone());
    cyc("ill_d", 1, 6'b111111, 6'h00, 0, 1, x(3'd1));
    e = x(3'd7); e.trap = 1'b1;
    for (int i = 0; i < 20; i++)
      cyc("trap_hold", 1, 6'b111111, 6'h00, i[0], 1, e);
    cyc("trap_rst", 0, 6'b111111, 6'h00, 0, 1, x(3'd0));
    cyc("trap_rel", 1, 6'h00, 6'b000001, 0, 1, fdone());

    // illegal funct traps too
    cyc("illf_d", 1, 6'h00, 6'b000001, 0, 1, x(3'd1));
    e = x(3'd7); e.trap = 1'b1;
    cyc("illf_t", 1, 6'h00, 6'b000001, 0, 1, e);

    repeat (5) @(posedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d expected=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS-subset datapath. It sequences fetch, decode, execute, memory and write-back over several clock cycles, so a single-port unified memory can serve both instruction fetch and data access. It drives every datapath strobe and mux select (PC, IR, register file, ALU, memory) and stalls on a request/ready memory handshake. Illegal opcodes trap.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed the current access this cycle
- pc_we  out  1  PC load enable
- pc_src  out  2  PC source: 00 PC+4, 01 branch target (PC+sext(imm)<<2), 10 jump target
- ir_we  out  1  IR load enable (memory read data into IR)
- mem_req  out  1  memory access request
- mem_we  out  1  memory write (meaningful only while mem_req=1)
- iord  out  1  memory address: 0 PC, 1 ALU result
- rf_we  out  1  register-file write enable
- wsel_rt  out  1  destination register: 1 rt, 0 rd
- wb_mem  out  1  write-back data: 1 memory data register, 0 ALU result register
- srca_shamt  out  1  ALU A: 1 zero-extended shamt, 0 rs
- srcb_imm  out  1  ALU B: 1 extended immediate, 0 rt
- sign_ext  out  1  immediate extension: 1 sign, 0 zero
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOR, 110 SLT, 111 SLL
- trap  out  1  sticky illegal-instruction flag
- state_o  out  3  current state, for debug

## Operation
State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.

Legal instructions:
- R-type (op 000000): sll 000000, addu 100001, subu 100011, and 100100, or 100101, xor 100110, nor 100111, slt 101010.
- I-type and jump opcodes: j 000010, beq 000100, bne 000101, addiu 001001 (sign), slti 001010 (sign), andi 001100 (zero), ori 001101 (zero), xori 001110 (zero), lw 100011 (sign), sw 101011 (sign).
- Any other op, or any other funct when op=000000, is illegal.

State behaviour:
- FETCH: mem_req=1, iord=0, mem_we=0. In the cycle mem_ready=1: ir_we=1, pc_we=1, pc_src=00, next state DECODE. Otherwise remain in FETCH.
- DECODE: one cycle; the datapath reads registers. Illegal instruction: go to TRAP. j: pc_we=1, pc_src=10, go to FETCH. All other instructions go to EXEC.
- EXEC: alu_op, srca_shamt, srcb_imm and sign_ext are driven for the instruction.
  - R-type and ALU immediates go to WB.
  - lw and sw use ADD with srcb_imm=1 and go to MEM.
  - beq and bne use SUB with srcb_imm=0 and pc_src=01. pc_we=zero for beq, pc_we=~zero for bne. Next state FETCH.
  - sll uses srca_shamt=1, srcb=rt.
- MEM: mem_req=1, iord=1, mem_we=1 for sw only. Wait for mem_ready, then lw goes to WB and sw goes to FETCH.
- WB: rf_we=1 for exactly one cycle. wsel_rt=1 for I-type, 0 for R-type. wb_mem=1 for lw. Next state FETCH.
- TRAP: all strobes are 0 and trap=1. The controller stays in TRAP until reset.
- Select outputs (iord, wsel_rt, wb_mem, srca_shamt, srcb_imm, sign_ext, pc_src, alu_op) default to 0 wherever they are not specified above.

## Timing
- Reset low: state goes to FETCH asynchronously. All strobes (pc_we, ir_we, mem_req, mem_we, rf_we) are 0 and trap=0 while reset is low. The first request is issued in the first cycle after reset deasserts.
- Strobes are combinational from the state plus zero/mem_ready. They must be glitch-free relative to the clock edge, meaning they settle before the next rising edge.
- Handshake:
  - mem_req, iord and mem_we stay stable until the cycle in which mem_ready=1 is sampled.
  - mem_ready is ignored while mem_req=0.
  - Zero wait states gives one cycle in FETCH/MEM. N wait states give N+1 cycles.
- Cycles per instruction with zero wait states: j 2, beq/bne 3, sw 4, R-type/immediate 4, lw 5.
- Reset asserted mid-access aborts it. Memory must tolerate mem_req dropping without mem_ready.
- op and funct must stay stable from DECODE until the next FETCH completes. IR only loads while ir_we=1.

## Structure
- Package mc_pkg holds the state encoding, opcode and funct constants, alu_op codes and pc_src codes.
- Sub-module mc_decode is purely combinational. It maps op/funct to instruction class (RTYPE, ALUI, LW, SW, BEQ, BNE, J), alu_op, sign_ext and illegal. mc_ctrl instantiates it once and contains the FSM and output logic.

## Test plan
- Reset release, then addu with mem_ready tied 1: FETCH → DECODE → EXEC → WB → FETCH. pc_we pulses once in FETCH. rf_we pulses once in WB with wsel_rt=0 and alu_op=000.
- lw with mem_ready delayed 2 cycles in both FETCH and MEM: 9 cycles total. mem_req is held with iord=0, then with iord=1 and mem_we=0. WB asserts wb_mem=1 and wsel_rt=1.
- beq with zero=1, then bne with zero=1: beq gives pc_we=1 with pc_src=01 in EXEC; bne gives pc_we=0. Each takes 3 cycles.
- j: pc_we=1 and pc_src=10 in DECODE, back in FETCH on the next cycle. rf_we is never asserted.
- op=111111: DECODE → TRAP. trap=1 and mem_req=0 hold for 20 cycles. Asserting reset returns to FETCH with trap=0.
- Reset asserted during MEM wait for sw: mem_req and mem_we drop immediately. After release the controller is in FETCH and no rf_we has occurred.
